// File: rtl/clut_writer.sv
// Palette (CLUT) write sequencer: queues {BANK,IDX,COL} writes in a small FIFO and
// replays them to the palette RAM during blanking as SETUP/STROBE/HOLD cycles.
module clut_writer #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        CLK_6M,
  input  logic        CLR,
  input  logic        WR,
  input  logic        BANK,
  input  logic [7:0]  IDX,
  input  logic [11:0] COL,
  input  logic        BLANK,
  output logic        BUSY,
  output logic        ERR,
  output logic [8:0]  A,
  output logic [7:0]  DRG,
  output logic [3:0]  DB,
  output logic        WE_n,
  output logic        DONE
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  logic [20:0]   fifo_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  state_t        state_q, state_d;
  logic          err_q, err_d;
  logic [8:0]    a_q, a_d;
  logic [7:0]    drg_q, drg_d;
  logic [3:0]    db_q, db_d;
  logic          we_n_q, we_n_d;
  logic          done_q, done_d;
  logic          busy;
  logic          push;
  logic          pop;
  logic [20:0]   head;

  assign busy = (count_q == FULL);
  assign head = fifo_q[rd_ptr_q];

  always_comb begin
    push     = WR && !busy;
    pop      = (state_q == IDLE) && (count_q != '0) && BLANK;
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
    err_d = err_q || (WR && busy);

    state_d = state_q;
    case (state_q)
      IDLE:    if (pop) state_d = SETUP;
      SETUP:   state_d = STROBE;
      STROBE:  state_d = HOLD;
      HOLD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // RAM address/data change only when a new entry is popped, so they stay
    // stable around the strobe and between sequences.
    a_d   = a_q;
    drg_d = drg_q;
    db_d  = db_q;
    if (pop) begin
      a_d   = head[20:12];
      drg_d = head[11:4];
      db_d  = head[3:0];
    end

    we_n_d = (state_d != STROBE);
    done_d = (state_d == HOLD);
  end

  always_ff @(posedge CLK_6M) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= {BANK, IDX, COL};
    end
  end

  always_ff @(posedge CLK_6M or negedge CLR) begin
    if (!CLR) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
      a_q      <= '0;
      drg_q    <= '0;
      db_q     <= '0;
      we_n_q   <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      err_q    <= err_d;
      a_q      <= a_d;
      drg_q    <= drg_d;
      db_q     <= db_d;
      we_n_q   <= we_n_d;
      done_q   <= done_d;
    end
  end

  assign BUSY = busy;
  assign ERR  = err_q;
  assign A    = a_q;
  assign DRG  = drg_q;
  assign DB   = db_q;
  assign WE_n = we_n_q;
  assign DONE = done_q;

endmodule

// File: tb/tb_clut_writer.sv
// Scoreboard bench for clut_writer: accepted writes queue their expected RAM
// address/data, and a negedge monitor checks every WE_n strobe against the queue.
module tb_clut_writer;

  logic        CLK_6M = 1'b0;
  logic        CLR;
  logic        WR;
  logic        BANK;
  logic [7:0]  IDX;
  logic [11:0] COL;
  logic        BLANK;
  logic        BUSY;
  logic        ERR;
  logic [8:0]  A;
  logic [7:0]  DRG;
  logic [3:0]  DB;
  logic        WE_n;
  logic        DONE;

  typedef struct packed {
    logic [8:0] a;
    logic [7:0] drg;
    logic [3:0] db;
  } exp_t;

  exp_t sb[$];
  int   n_compared    = 0;
  int   n_mismatch    = 0;
  int   strobe_count  = 0;
  int   cyc           = 0;
  int   last_strobe   = 0;
  bit   check_spacing = 1'b0;
  bit   have_last     = 1'b0;
  bit   prev_strobe   = 1'b0;

  clut_writer #(.FIFO_DEPTH(4)) dut (
    .CLK_6M(CLK_6M), .CLR(CLR), .WR(WR), .BANK(BANK), .IDX(IDX), .COL(COL),
    .BLANK(BLANK), .BUSY(BUSY), .ERR(ERR), .A(A), .DRG(DRG), .DB(DB),
    .WE_n(WE_n), .DONE(DONE)
  );

  always #5 CLK_6M = ~CLK_6M;

  always @(posedge CLK_6M) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatch++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Called at a falling edge; the expected RAM write is queued only if the
  // FIFO is known (by hand) to accept this request.
  task automatic applyStimulus(input logic wr, input logic [20:0] entry, input bit accept);
    exp_t e;
    WR = wr;
    {BANK, IDX, COL} = entry;
    if (wr && accept) begin
      e.a   = {entry[20], entry[19:12]};
      e.drg = {entry[11:8], entry[7:4]};
      e.db  = entry[3:0];
      sb.push_back(e);
    end
  endtask

  task automatic waitDrain(input int budget);
    int n = 0;
    while ((sb.size() != 0) && (n < budget)) begin
      @(negedge CLK_6M);
      n++;
    end
    checkOutput("drain_queue_left", sb.size(), 0);
    repeat (3) @(negedge CLK_6M);
  endtask

  always @(negedge CLK_6M) begin
    exp_t e;
    if (!CLR) begin
      prev_strobe = 1'b0;
    end else begin
      checkOutput("done_follows_strobe", 32'(DONE), 32'(prev_strobe));
      if (prev_strobe) checkOutput("we_n_one_clock", 32'(WE_n), 32'(1));
      if (!WE_n) begin
        strobe_count++;
        checkOutput("strobe_has_expected", 32'(sb.size() != 0), 32'(1));
        if (sb.size() != 0) begin
          e = sb.pop_front();
          checkOutput("ram_addr", 32'(A), 32'(e.a));
          checkOutput("ram_drg", 32'(DRG), 32'(e.drg));
          checkOutput("ram_db", 32'(DB), 32'(e.db));
        end
        if (check_spacing && have_last) checkOutput("strobe_spacing", cyc - last_strobe, 4);
        last_strobe = cyc;
        have_last   = 1'b1;
      end
      prev_strobe = !WE_n;
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int saved;
    int guard;
    logic [20:0] ent;
    bit acc;

    CLR = 1'b1; WR = 1'b0; BANK = 1'b0; IDX = '0; COL = '0; BLANK = 1'b0;
    #1 CLR = 1'b0;
    #11;
    checkOutput("rst_busy", 32'(BUSY), 32'(0));
    checkOutput("rst_err", 32'(ERR), 32'(0));
    checkOutput("rst_a", 32'(A), 32'(0));
    checkOutput("rst_drg", 32'(DRG), 32'(0));
    checkOutput("rst_db", 32'(DB), 32'(0));
    checkOutput("rst_we_n", 32'(WE_n), 32'(1));
    checkOutput("rst_done", 32'(DONE), 32'(0));

    // Single write during blanking
    @(negedge CLK_6M);
    CLR = 1'b1; BLANK = 1'b1;
    applyStimulus(1'b1, {1'b1, 8'h5A, 12'hF3C}, 1'b1);
    @(negedge CLK_6M);
    applyStimulus(1'b0, '0, 1'b0);
    waitDrain(20);
    checkOutput("single_a_held", 32'(A), 32'h15A);
    checkOutput("single_drg_held", 32'(DRG), 32'hF3);
    checkOutput("single_db_held", 32'(DB), 32'hC);
    checkOutput("single_strobes", strobe_count, 1);

    // Fill while not blanked, overflow, then drain on blanking
    BLANK = 1'b0;
    saved = strobe_count;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK_6M);
      applyStimulus(1'b1, {i[0], 8'hA0 + 8'(i), 12'h123 + 12'(i * 'h111)}, 1'b1);
    end
    @(negedge CLK_6M);
    checkOutput("full_busy", 32'(BUSY), 32'(1));
    checkOutput("full_err_before", 32'(ERR), 32'(0));
    applyStimulus(1'b1, {1'b1, 8'hEE, 12'hEEE}, 1'b0);
    @(negedge CLK_6M);
    applyStimulus(1'b0, '0, 1'b0);
    checkOutput("overflow_err", 32'(ERR), 32'(1));
    checkOutput("overflow_busy", 32'(BUSY), 32'(1));
    repeat (5) @(negedge CLK_6M);
    checkOutput("no_strobe_unblanked", strobe_count, saved);
    have_last = 1'b0; check_spacing = 1'b1;
    BLANK = 1'b1;
    @(negedge CLK_6M);
    checkOutput("busy_clears_on_pop", 32'(BUSY), 32'(0));
    waitDrain(40);
    checkOutput("burst_strobes", strobe_count, saved + 4);
    checkOutput("err_sticky", 32'(ERR), 32'(1));
    check_spacing = 1'b0;

    // BLANK falls while strobing: sequence completes, next waits for BLANK
    @(negedge CLK_6M);
    saved = strobe_count;
    applyStimulus(1'b1, {1'b0, 8'h33, 12'h4B7}, 1'b1);
    @(negedge CLK_6M);
    applyStimulus(1'b1, {1'b1, 8'hC4, 12'h0D9}, 1'b1);
    @(negedge CLK_6M);
    applyStimulus(1'b0, '0, 1'b0);
    guard = 0;
    while (WE_n && guard < 20) begin
      @(negedge CLK_6M);
      guard++;
    end
    checkOutput("blank_drop_strobe_seen", 32'(WE_n), 32'(0));
    BLANK = 1'b0;
    repeat (10) @(negedge CLK_6M);
    checkOutput("blank_drop_one_strobe", strobe_count, saved + 1);
    BLANK = 1'b1;
    waitDrain(20);
    checkOutput("blank_resume_strobes", strobe_count, saved + 2);

    // Reset asserted during STROBE
    @(negedge CLK_6M);
    saved = strobe_count;
    applyStimulus(1'b1, {1'b1, 8'h01, 12'h111}, 1'b1);
    @(negedge CLK_6M);
    applyStimulus(1'b1, {1'b0, 8'h02, 12'h222}, 1'b1);
    @(negedge CLK_6M);
    applyStimulus(1'b1, {1'b1, 8'h03, 12'h333}, 1'b1);
    @(negedge CLK_6M);
    applyStimulus(1'b0, '0, 1'b0);
    guard = 0;
    while (WE_n && guard < 20) begin
      @(negedge CLK_6M);
      guard++;
    end
    checkOutput("reset_strobe_seen", 32'(WE_n), 32'(0));
    #2 CLR = 1'b0;
    #1;
    checkOutput("areset_we_n", 32'(WE_n), 32'(1));
    checkOutput("areset_a", 32'(A), 32'(0));
    checkOutput("areset_drg", 32'(DRG), 32'(0));
    checkOutput("areset_db", 32'(DB), 32'(0));
    checkOutput("areset_done", 32'(DONE), 32'(0));
    checkOutput("areset_busy", 32'(BUSY), 32'(0));
    checkOutput("areset_err", 32'(ERR), 32'(0));
    sb.delete();
    saved = strobe_count;
    repeat (2) @(negedge CLK_6M);
    CLR = 1'b1;
    repeat (12) @(negedge CLK_6M);
    checkOutput("discarded_never_written", strobe_count, saved);

    // Continuous WR with blanking: writes accepted at 0..4, 6, 10, 14, 18
    CLR = 1'b0;
    @(negedge CLK_6M);
    CLR = 1'b1;
    have_last = 1'b0; check_spacing = 1'b1;
    saved = strobe_count;
    for (int t = 0; t < 20; t++) begin
      if (t > 0) begin
        @(negedge CLK_6M);
        checkOutput("stream_err", 32'(ERR), 32'((t - 1) >= 5));
      end
      ent = {t[0], 8'h10 + 8'(t), t[3:0], ~t[3:0], t[3:0] ^ 4'h5};
      acc = (t <= 4) || (t >= 6 && ((t - 6) % 4) == 0);
      applyStimulus(1'b1, ent, acc);
    end
    @(negedge CLK_6M);
    checkOutput("stream_err_end", 32'(ERR), 32'(1));
    applyStimulus(1'b0, '0, 1'b0);
    waitDrain(80);
    checkOutput("stream_strobes", strobe_count, saved + 9);
    check_spacing = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
    $finish;
  end

endmodule
